// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: blink, rotate, ping-pong and binary count patterns,
// stepped by a prescaled base tick with an optional step budget.
module led_pattern_ctrl #(
  parameter int TICK_CNT = 49999999,
  parameter int CNT_W    = 26,
  parameter int LED_W    = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic [7:0]       steps,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             step_o,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start; led holds last pattern (or 0 after stop)
  // RUN   | prescaler running, pattern advances on each step_tick
  // DONE  | one-cycle state after the last budgeted step (done pulse)
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_CNT);
  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] pre, pre_n;
  logic [1:0]       sub, sub_n;
  logic [7:0]       cnt, cnt_n;
  logic             dir, dir_n;            // 0 = moving left (towards MSB)
  logic [1:0]       mode_q, mode_n;
  logic [1:0]       speed_q, speed_n;
  logic [7:0]       steps_q, steps_n;
  logic [LED_W-1:0] led_n, step_led;
  logic             step_dir, step_n;
  logic             base_tick, step_tick, last_step;

  assign base_tick = (pre == TICK_MAX);
  assign step_tick = base_tick && (sub == speed_q);
  assign last_step = (steps_q != 8'd0) && (cnt == steps_q - 8'd1);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Next pattern for the latched mode
  always_comb begin
    step_led = led;
    step_dir = dir;
    case (mode_q)
      2'd0: step_led = ~led;
      2'd1: step_led = {led[LED_W-2:0], led[LED_W-1]};
      2'd2: begin
        if (!dir) begin
          if (led[LED_W-1]) begin
            step_led = led >> 1;
            step_dir = 1'b1;
          end else begin
            step_led = led << 1;
          end
        end else begin
          if (led[0]) begin
            step_led = led << 1;
            step_dir = 1'b0;
          end else begin
            step_led = led >> 1;
          end
        end
      end
      default: step_led = led + LED_ONE;
    endcase
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    sub_n   = sub;
    cnt_n   = cnt;
    dir_n   = dir;
    mode_n  = mode_q;
    speed_n = speed_q;
    steps_n = steps_q;
    led_n   = led;
    step_n  = 1'b0;
    case (state)
      IDLE: begin
        if (stop) begin
          led_n = '0;
        end else if (start) begin
          state_n = RUN;
          mode_n  = mode;
          speed_n = speed;
          steps_n = steps;
          pre_n   = '0;
          sub_n   = '0;
          cnt_n   = '0;
          dir_n   = 1'b0;
          case (mode)
            2'd0:    led_n = '1;
            2'd3:    led_n = '0;
            default: led_n = LED_ONE;
          endcase
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          led_n   = '0;
          pre_n   = '0;
          sub_n   = '0;
        end else begin
          pre_n = base_tick ? '0 : pre + CNT_W'(1);
          if (base_tick) sub_n = (sub == speed_q) ? 2'd0 : sub + 2'd1;
          if (step_tick) begin
            led_n  = step_led;
            dir_n  = step_dir;
            step_n = 1'b1;
            cnt_n  = cnt + 8'd1;
            if (last_step) state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        if (stop) begin
          led_n = '0;
          pre_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state   <= IDLE;
      pre     <= '0;
      sub     <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      mode_q  <= '0;
      speed_q <= '0;
      steps_q <= '0;
      led     <= '0;
      step_o  <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      sub     <= sub_n;
      cnt     <= cnt_n;
      dir     <= dir_n;
      mode_q  <= mode_n;
      speed_q <= speed_n;
      steps_q <= steps_n;
      led     <= led_n;
      step_o  <= step_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a 4-cycle base tick.
module tb_led_pattern_ctrl;

  logic       sclk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode, speed;
  logic [7:0] steps;
  logic [3:0] led;
  logic       busy, step_o, done;

  int checks   = 0;
  int failures = 0;

  led_pattern_ctrl #(.TICK_CNT(3), .CNT_W(4), .LED_W(4)) dut (
    .sclk(sclk), .rst(rst), .start(start), .stop(stop),
    .mode(mode), .speed(speed), .steps(steps),
    .led(led), .busy(busy), .step_o(step_o), .done(done)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [1:0]        mode;
    logic [1:0]        speed;
    logic [7:0]        steps;
    int                nobs;
    logic [3:0]        init;
    logic [0:16][3:0]  seq;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Accept a start; afterwards scramble config inputs to show they are ignored.
  task automatic do_start(input logic [1:0] m, input logic [1:0] s, input logic [7:0] n);
    start = 1'b1; mode = m; speed = s; steps = n;
    tick();
    start = 1'b0; mode = ~m; speed = ~s; steps = ~n;
  endtask

  task automatic wait_step(input int per, input logic [3:0] exp_led, input logic exp_done);
    int c = 0;
    while (c < 64) begin
      tick();
      c++;
      if (step_o) break;
      chk("done_between_steps", 32'(done), 32'(0));
    end
    chk("step_seen", 32'(step_o), 32'(1));
    chk("step_period", 32'(c), 32'(per));
    chk("step_led", 32'(led), 32'(exp_led));
    chk("step_done", 32'(done), 32'(exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd1, 2'd0, 8'd0,  5, 4'h1, 68'h2481_2000_0000_0000_0};
    vecs[1] = '{2'd2, 2'd1, 8'd7,  7, 4'h1, 68'h2484_2120_0000_0000_0};
    vecs[2] = '{2'd3, 2'd0, 8'd17, 17, 4'h0, 68'h1234_5678_9ABC_DEF0_1};
    vecs[3] = '{2'd0, 2'd2, 8'd3,  3, 4'hF, 68'h0F00_0000_0000_0000_0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; speed = '0; steps = '0;
    tick(); tick();
    chk("rst_led", 32'(led), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_step", 32'(step_o), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      do_start(vecs[i].mode, vecs[i].speed, vecs[i].steps);
      chk("start_led", 32'(led), 32'(vecs[i].init));
      chk("start_busy", 32'(busy), 32'(1));
      for (int k = 0; k < vecs[i].nobs; k++)
        wait_step(4 * (int'(vecs[i].speed) + 1), vecs[i].seq[k],
                  (vecs[i].steps != 0) && (k == int'(vecs[i].steps) - 1));
      if (vecs[i].steps != 0) begin
        tick();
        chk("after_done_busy", 32'(busy), 32'(0));
        chk("after_done_led", 32'(led), 32'(vecs[i].seq[vecs[i].nobs-1]));
        chk("after_done_pulse", 32'(done), 32'(0));
        tick();
        chk("idle_hold_led", 32'(led), 32'(vecs[i].seq[vecs[i].nobs-1]));
      end else begin
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_led", 32'(led), 32'(0));
        chk("stop_busy", 32'(busy), 32'(0));
      end
    end

    // stop two cycles before a step_tick
    do_start(2'd0, 2'd0, 8'd0);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("early_stop_led", 32'(led), 32'(0));
    chk("early_stop_busy", 32'(busy), 32'(0));
    chk("early_stop_done", 32'(done), 32'(0));
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("idle_no_step", 32'(step_o), 32'(0));
    end
    chk("idle_led_zero", 32'(led), 32'(0));

    // stop coinciding with a step_tick suppresses it
    do_start(2'd0, 2'd0, 8'd0);
    tick(); tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("tick_stop_step", 32'(step_o), 32'(0));
    chk("tick_stop_led", 32'(led), 32'(0));
    chk("tick_stop_busy", 32'(busy), 32'(0));

    // stop coinciding with the last step: no done
    do_start(2'd3, 2'd0, 8'd1);
    tick(); tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("last_stop_done", 32'(done), 32'(0));
    chk("last_stop_led", 32'(led), 32'(0));
    chk("last_stop_busy", 32'(busy), 32'(0));

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; mode = 2'd0; tick(); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'(0));
    chk("startstop_led", 32'(led), 32'(0));

    // start during RUN is ignored
    do_start(2'd1, 2'd0, 8'd3);
    tick();
    start = 1'b1; mode = 2'd3; speed = 2'd3; steps = 8'd1;
    tick();
    start = 1'b0;
    wait_step(2, 4'h2, 1'b0);
    wait_step(4, 4'h4, 1'b0);
    wait_step(4, 4'h8, 1'b1);
    tick();
    chk("ign_after_busy", 32'(busy), 32'(0));
    chk("ign_after_led", 32'(led), 32'(8));

    // stop alone in IDLE clears the held pattern
    stop = 1'b1; tick(); stop = 1'b0;
    chk("idle_stop_led", 32'(led), 32'(0));

    // reset mid-run, then a normal run
    do_start(2'd3, 2'd0, 8'd0);
    repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_led", 32'(led), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_step", 32'(step_o), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    do_start(2'd1, 2'd0, 8'd2);
    chk("post_rst_start_led", 32'(led), 32'(1));
    wait_step(4, 4'h2, 1'b0);
    wait_step(4, 4'h4, 1'b1);
    tick();
    chk("post_rst_idle", 32'(busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
